// File: rtl/onehot_decode_164_pkg.sv
// onehot_decode_164_pkg: default widths, occupancy states and the entry type shared by the decoder files
package onehot_decode_164_pkg;
  localparam int DEF_IDX_W = 4;
  localparam int DEF_OUT_W = 16;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;
  typedef struct packed {
    logic [DEF_OUT_W-1:0] onehot;
    logic err;
  } entry_t;
endpackage

// File: rtl/onehot_decode_164_if.sv
// onehot_decode_164_if: in_* upstream handshake, out_* downstream handshake, seen_mask/clr_seen sticky mask; slave = decoder side
interface onehot_decode_164_if
  import onehot_decode_164_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int OUT_W = DEF_OUT_W
);
  logic in_valid, in_ready, in_any;
  logic [IDX_W-1:0] in_idx;
  logic out_valid, out_ready, out_err;
  logic [OUT_W-1:0] out_onehot, seen_mask;
  logic clr_seen;
  modport master (
    output in_valid, in_idx, in_any, out_ready, clr_seen,
    input in_ready, out_valid, out_onehot, out_err, seen_mask
  );
  modport slave (
    input in_valid, in_idx, in_any, out_ready, clr_seen,
    output in_ready, out_valid, out_onehot, out_err, seen_mask
  );
endinterface

// File: rtl/onehot_decode_164_comb.sv
// onehot_decode_comb: combinational {any_i, idx_i} -> {onehot_o, err_o}; range check done one bit wider than idx_i
module onehot_decode_comb
  import onehot_decode_164_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             any_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [OUT_W-1:0] onehot_o,
  output logic             err_o
);
  logic oor;
  assign oor = {1'b0, idx_i} >= (IDX_W+1)'(OUT_W);
  assign err_o = any_i & oor;
  assign onehot_o = (any_i & ~oor) ? OUT_W'(1) << idx_i : '0;
endmodule

// File: rtl/onehot_decode_164.sv
// onehot_decode_164: index-to-one-hot decoder with 2-entry skid, sticky seen mask; ports clk, rst_n (async low), bus (slave modport)
module onehot_decode_164
  import onehot_decode_164_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  onehot_decode_164_if.slave   bus
);
  if (OUT_W > 2**IDX_W) begin : g_bad_width
    $error("OUT_W must not exceed 2**IDX_W");
  end
  typedef struct packed {
    logic [OUT_W-1:0] onehot;
    logic err;
  } ent_t;
  occ_e state_q, state_d;
  ent_t out_q, out_d, skid_q, skid_d, dec;
  logic [OUT_W-1:0] seen_q, seen_d, dec_oh;
  logic dec_err, in_ready_q, acc, xfer;
  onehot_decode_comb #(.IDX_W(IDX_W), .OUT_W(OUT_W)) u_dec (
    .any_i(bus.in_any),
    .idx_i(bus.in_idx),
    .onehot_o(dec_oh),
    .err_o(dec_err)
  );
  assign dec = '{onehot: dec_oh, err: dec_err};
  assign acc = bus.in_valid & in_ready_q;
  assign xfer = bus.out_ready & (state_q != EMPTY);
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    skid_d = skid_q;
    seen_d = bus.clr_seen ? (acc ? dec.onehot : '0) : (acc ? seen_q | dec.onehot : seen_q);
    case (state_q)
      EMPTY: if (acc) begin
        state_d = ONE;
        out_d = dec;
      end
      ONE: if (acc && xfer) out_d = dec;
      else if (acc) begin
        state_d = TWO;
        skid_d = dec;
      end
      else if (xfer) state_d = EMPTY;
      TWO: if (xfer) begin
        state_d = ONE;
        out_d = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q <= '0;
      skid_q <= '0;
      seen_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      skid_q <= skid_d;
      seen_q <= seen_d;
      in_ready_q <= state_d != TWO;
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = state_q != EMPTY;
  assign bus.out_onehot = out_q.onehot;
  assign bus.out_err = out_q.err;
  assign bus.seen_mask = seen_q;
endmodule
